// File: rtl/run_monitor.sv
// Run-control monitor: counts run cycles until the end sentinel or a timeout.
// After the sentinel it drains the pipeline, then streams the register file out.
module run_monitor #(
  parameter int                DATA_W       = 32,
  parameter int                CNT_W        = 32,
  parameter int                TIMEOUT      = 100,
  parameter logic [DATA_W-1:0] END_INSTR    = {DATA_W{1'b0}},
  parameter int                DRAIN_CYCLES = 5,
  parameter int                NUM_REGS     = 32,
  parameter int                REG_AW       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic [REG_AW-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [REG_AW-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int DW = (DRAIN_CYCLES > 32'sd1) ? $clog2(DRAIN_CYCLES) : 32'sd1;
  localparam logic [CNT_W-1:0]  TMO_VAL    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [DW-1:0]     DRAIN_LAST = DW'((DRAIN_CYCLES > 32'sd0) ? (DRAIN_CYCLES - 32'sd1) : 32'sd0);
  localparam logic [REG_AW-1:0] LAST_IDX   = REG_AW'(NUM_REGS - 32'sd1);
  localparam bit                NO_DRAIN   = (DRAIN_CYCLES == 32'sd0);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_DRAIN = 3'd1,
    S_DUMP  = 3'd2,
    S_DONE  = 3'd3,
    S_TMO   = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DW-1:0]     drain_r;
  logic [REG_AW-1:0] idx_r;
  logic              end_det_s;
  logic              xfer_s;

  assign end_det_s = (state_r == S_RUN) && instr_valid && (instr == END_INSTR);
  assign xfer_s    = (state_r == S_DUMP) && dump_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; an end detect outranks a timeout in the same cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_RUN: begin
        if (end_det_s) begin
          state_s = NO_DRAIN ? S_DUMP : S_DRAIN;
        end else if (cnt_r == TMO_VAL) begin
          state_s = S_TMO;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_s = S_DUMP;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DUMP: begin
        if (xfer_s && (idx_r == LAST_IDX)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DUMP;
        end
      end
      S_DONE:  state_s = S_DONE;
      S_TMO:   state_s = S_TMO;
      default: state_s = S_RUN;
    endcase
  end

  // Run-cycle, drain and dump-index counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      drain_r <= {DW{1'b0}};
      idx_r   <= {REG_AW{1'b0}};
    end else begin
      // The sentinel cycle and the timeout cycle are not counted
      if ((state_r == S_RUN) && !end_det_s && (cnt_r != TMO_VAL) && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
      if (state_r == S_DRAIN) begin
        drain_r <= (drain_r == DRAIN_LAST) ? {DW{1'b0}} : (drain_r + DW'(1'b1));
      end
      if (xfer_s && (idx_r != LAST_IDX)) begin
        idx_r <= idx_r + REG_AW'(1'b1);
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    dump_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state_r)
      S_RUN:   busy = 1'b1;
      S_DRAIN: busy = 1'b1;
      S_DUMP: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
      end
      S_DONE:  done    = 1'b1;
      S_TMO:   timeout = 1'b1;
      default: busy    = 1'b0;
    endcase
  end

  assign rf_rd_addr  = idx_r;
  assign dump_idx    = idx_r;
  assign dump_data   = rf_rd_data;
  assign cycle_count = cnt_r;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: default instance plus a small instance
// (no drain, 4 registers, 4-bit counter) with a scoreboard for dump beats.
module tb_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, iv, rdy, dv, busy, done, tmo;
  logic [31:0] ins, rdata, ddata, cc;
  logic [4:0]  addr, didx;

  logic        rst2, iv2, rdy2, dv2, busy2, done2, tmo2;
  logic [31:0] ins2, rdata2, ddata2;
  logic [1:0]  addr2, didx2;
  logic [3:0]  cc2;

  // Register-file models: register i holds i*3
  assign rdata  = 32'(addr) * 32'd3;
  assign rdata2 = 32'(addr2) * 32'd3;

  run_monitor dut (
    .clk(clk), .rst(rst), .instr_valid(iv), .instr(ins),
    .rf_rd_addr(addr), .rf_rd_data(rdata),
    .dump_valid(dv), .dump_ready(rdy), .dump_idx(didx), .dump_data(ddata),
    .cycle_count(cc), .busy(busy), .done(done), .timeout(tmo)
  );

  run_monitor #(.CNT_W(4), .TIMEOUT(15), .DRAIN_CYCLES(0), .NUM_REGS(4), .REG_AW(2)) dut2 (
    .clk(clk), .rst(rst2), .instr_valid(iv2), .instr(ins2),
    .rf_rd_addr(addr2), .rf_rd_data(rdata2),
    .dump_valid(dv2), .dump_ready(rdy2), .dump_idx(didx2), .dump_data(ddata2),
    .cycle_count(cc2), .busy(busy2), .done(done2), .timeout(tmo2)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t sbq[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset1();
    rst = 1'b1; iv = 1'b0; ins = 32'd0; rdy = 1'b0;
    step();
    step();
    sbq.delete();
  endtask

  // k counted cycles (cycle 5 carries an unqualified sentinel), then the sentinel
  task automatic run1(input int k);
    for (int i = 0; i < k; i++) begin
      if (i == 5) begin
        iv = 1'b0; ins = 32'd0;
      end else begin
        iv = ($urandom_range(0, 3) != 0); ins = $urandom | 32'd1;
      end
      step();
    end
    check("cc_before_end", 64'(cc), 64'(k));
    check("busy_run", 64'(busy), 64'd1);
    iv = 1'b1; ins = 32'd0;
    for (int i = 0; i < 32; i++) sbq.push_back('{idx: 5'(i), data: 32'(i * 3)});
    step();
    check("cc_frozen", 64'(cc), 64'(k));
    check("busy_drain", 64'(busy), 64'd1);
    check("tmo_after_end", 64'(tmo), 64'd0);
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1
  task automatic dump1(input int mode, input int abort_after, output int beats);
    int          c, g;
    logic        stalled;
    logic [4:0]  pidx;
    logic [31:0] pdata;
    beat_t       e;
    c = 0; g = 0; beats = 0; stalled = 1'b0; pidx = 5'd0; pdata = 32'd0;
    while (!dv && g < 50) begin
      g++;
      step();
    end
    check("drain_gap", 64'(g), 64'd5);
    while (dv && c < 400 && beats < abort_after) begin
      if (stalled) begin
        check("stall_idx", 64'(didx), 64'(pidx));
        check("stall_data", 64'(ddata), 64'(pdata));
      end
      check("addr_eq_idx", 64'(addr), 64'(didx));
      rdy = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (rdy) begin
        check("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("beat_idx", 64'(didx), 64'(e.idx));
          check("beat_data", 64'(ddata), 64'(e.data));
        end
        beats++;
      end
      stalled = !rdy; pidx = didx; pdata = ddata;
      c++;
      step();
    end
    rdy = 1'b0;
  endtask

  initial begin
    int n, c;
    logic seen_dv;
    beat_t e;

    rst2 = 1'b1; iv2 = 1'b0; ins2 = 32'd0; rdy2 = 1'b0;
    reset1();
    check("rst_cc", 64'(cc), 64'd0);
    check("rst_dv", 64'(dv), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tmo", 64'(tmo), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);

    // End detect and full dump with ready held high
    rst = 1'b0;
    run1(12);
    dump1(0, 1000, n);
    check("t1_beats", 64'(n), 64'd32);
    check("t1_sb_empty", 64'(sbq.size()), 64'd0);
    check("t1_done", 64'(done), 64'd1);
    check("t1_tmo", 64'(tmo), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_dv", 64'(dv), 64'd0);
    step();
    step();
    check("t1_done_sticky", 64'(done), 64'd1);
    check("t1_cc_hold", 64'(cc), 64'd12);

    // Backpressure
    reset1();
    rst = 1'b0;
    run1(20);
    dump1(1, 1000, n);
    check("t3_beats", 64'(n), 64'd32);
    check("t3_sb_empty", 64'(sbq.size()), 64'd0);
    check("t3_done", 64'(done), 64'd1);

    // Sentinel coincides with cycle_count == TIMEOUT
    reset1();
    rst = 1'b0;
    run1(100);
    dump1(0, 1000, n);
    check("t4_beats", 64'(n), 64'd32);
    check("t4_done", 64'(done), 64'd1);
    check("t4_tmo", 64'(tmo), 64'd0);
    check("t4_cc", 64'(cc), 64'd100);

    // Timeout without sentinel
    reset1();
    rst = 1'b0;
    c = 0; seen_dv = 1'b0;
    while (!tmo && c < 200) begin
      iv = 1'b1; ins = $urandom | 32'd1;
      step();
      c++;
      if (dv) seen_dv = 1'b1;
    end
    check("t2_tmo_cycle", 64'(c), 64'd101);
    check("t2_cc", 64'(cc), 64'd100);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_done", 64'(done), 64'd0);
    check("t2_no_dv", 64'(seen_dv), 64'd0);
    iv = 1'b1; ins = 32'd0;
    step();
    step();
    check("t2_tmo_sticky", 64'(tmo), 64'd1);
    check("t2_done_late", 64'(done), 64'd0);
    check("t2_cc_hold", 64'(cc), 64'd100);
    check("t2_dv_late", 64'(dv), 64'd0);

    // Reset mid-dump, then a clean full run
    reset1();
    rst = 1'b0;
    run1(12);
    dump1(0, 11, n);
    check("t5_partial", 64'(n), 64'd11);
    check("t5_dv_before", 64'(dv), 64'd1);
    rst = 1'b1; iv = 1'b0;
    step();
    check("t5_rst_dv", 64'(dv), 64'd0);
    check("t5_rst_cc", 64'(cc), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_addr", 64'(addr), 64'd0);
    sbq.delete();
    step();
    rst = 1'b0;
    run1(12);
    dump1(0, 1000, n);
    check("t5_beats", 64'(n), 64'd32);
    check("t5_done", 64'(done), 64'd1);
    rst = 1'b1;

    // Small instance: no drain, 4 registers, 4-bit counter
    rst2 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      iv2 = 1'b1; ins2 = $urandom | 32'd1;
      step();
    end
    check("t6_cc", 64'(cc2), 64'd7);
    iv2 = 1'b1; ins2 = 32'd0;
    for (int i = 0; i < 4; i++) sbq.push_back('{idx: 5'(i), data: 32'(i * 3)});
    step();
    iv2 = 1'b0;
    check("t6_dump_next", 64'(dv2), 64'd1);
    rdy2 = 1'b1; c = 0; n = 0;
    while (dv2 && c < 20) begin
      check("t6_sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("t6_beat_idx", 64'(didx2), 64'(e.idx));
        check("t6_beat_data", 64'(ddata2), 64'(e.data));
      end
      n++; c++;
      step();
    end
    rdy2 = 1'b0;
    check("t6_beats", 64'(n), 64'd4);
    check("t6_done", 64'(done2), 64'd1);
    check("t6_tmo", 64'(tmo2), 64'd0);
    check("t6_busy", 64'(busy2), 64'd0);
    check("t6_cc_hold", 64'(cc2), 64'd7);

    rst2 = 1'b1;
    step();
    step();
    rst2 = 1'b0; c = 0;
    while (!tmo2 && c < 40) begin
      iv2 = 1'b1; ins2 = $urandom | 32'd1;
      step();
      c++;
    end
    check("t6_tmo_cycle", 64'(c), 64'd16);
    check("t6_tmo_cc", 64'(cc2), 64'd15);
    check("t6_tmo_flag", 64'(tmo2), 64'd1);
    check("t6_tmo_done", 64'(done2), 64'd0);
    check("t6_tmo_dv", 64'(dv2), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
